// File: rtl/qm_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : qm_scoreboard
//  Description : Register write scoreboard for an in-order issue stage.
//                Tracks up to three in-flight writes per architectural
//                register (r1..r31), stalls decode on RAW hazards and WAW
//                counter overflow, and supports a drain handshake
//                (RUN -> DRAIN -> DONE -> RUN).
//  Ports       : sys_clk/sys_rst      clock, async active-high reset
//                ci_IssueValid..      decode instruction and its operands
//                di_WA/di_WE          writeback (retire) port
//                ci_Drain             drain request pulse
//                co_Stall/co_Issue    decode handshake
//                co_Drained           one-cycle drain-complete pulse
//                co_Pending           per-register in-flight flags
//                co_StallCount        saturating stalled-cycle counter
//                co_Error             sticky retire-without-pending flag
//  Revision    : 1.0  initial release
// ============================================================================
module qm_scoreboard (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ci_IssueValid,
    input  logic [4:0]  di_RS,
    input  logic [4:0]  di_RT,
    input  logic        ci_UsesRS,
    input  logic        ci_UsesRT,
    input  logic [4:0]  di_IssueWA,
    input  logic        ci_RegWrite,
    input  logic        ci_Flush,
    input  logic [4:0]  di_WA,
    input  logic        di_WE,
    input  logic        ci_Drain,
    output logic        co_Stall,
    output logic        co_Issue,
    output logic        co_Drained,
    output logic [31:0] co_Pending,
    output logic [15:0] co_StallCount,
    output logic        co_Error
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        w_not_run;

    logic [1:0]  w_cnt [0:31];
    logic [31:0] w_busy_nxt;

    logic        w_raw;
    logic        w_waw;
    logic        w_bad_retire;

    logic [15:0] r_stall_cnt;
    logic        r_error;

    // r0 is hard-wired: never pending, never counted.
    assign w_cnt[0]      = 2'b00;
    assign w_busy_nxt[0] = 1'b0;
    assign co_Pending[0] = 1'b0;

    // ------------------------------------------------------------------
    // Per-register in-flight write counters
    // ------------------------------------------------------------------
    generate
        for (genvar n = 1; n < 32; n++) begin : g_cnt
            localparam logic [4:0] c_IDX = 5'(n);
            logic [1:0] r_cnt;
            logic [1:0] w_nxt;
            logic       w_inc;
            logic       w_dec;

            // WAW stall guarantees w_inc never fires at count 3.
            assign w_inc = co_Issue & ci_RegWrite & (di_IssueWA == c_IDX);
            // A retire at count 0 is an error and must not wrap.
            assign w_dec = di_WE & (di_WA == c_IDX) & (r_cnt != 2'b00);

            always_comb begin
                w_nxt = r_cnt;
                case ({w_inc, w_dec})
                    2'b10:   w_nxt = r_cnt + 2'b01;
                    2'b01:   w_nxt = r_cnt - 2'b01;
                    default: w_nxt = r_cnt;
                endcase
            end

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_cnt <= 2'b00;
                end else begin
                    r_cnt <= w_nxt;
                end
            end

            assign w_cnt[n]      = r_cnt;
            assign w_busy_nxt[n] = |w_nxt;
            assign co_Pending[n] = |r_cnt;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detection (register 0 reads as never pending via w_cnt[0])
    // ------------------------------------------------------------------
    assign w_raw = (ci_UsesRS & (w_cnt[di_RS] != 2'b00))
                 | (ci_UsesRT & (w_cnt[di_RT] != 2'b00));
    assign w_waw = ci_RegWrite & (di_IssueWA != 5'd0) & (w_cnt[di_IssueWA] == 2'b11);

    assign co_Stall = ci_IssueValid & ~ci_Flush & (w_raw | w_waw | w_not_run);
    assign co_Issue = ci_IssueValid & ~ci_Flush & ~co_Stall;

    assign w_bad_retire = di_WE & (di_WA != 5'd0) & (w_cnt[di_WA] == 2'b00);

    // ------------------------------------------------------------------
    // Drain FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM: next state. DRAIN completes on the edge that empties the
    // scoreboard, so the check looks at the post-update counter values.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:   if (ci_Drain) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_busy_nxt == 32'd0) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_RUN;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        co_Drained = 1'b0;
        w_not_run  = 1'b1;
        case (r_state)
            c_ST_RUN:   w_not_run  = 1'b0;
            c_ST_DONE:  co_Drained = 1'b1;
            default:    w_not_run  = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Stall statistics and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_stall_cnt <= 16'd0;
            r_error     <= 1'b0;
        end else begin
            if (co_Stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_bad_retire) begin
                r_error <= 1'b1;
            end
        end
    end

    assign co_StallCount = r_stall_cnt;
    assign co_Error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_qm_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qm_scoreboard
//  Description : Directed, table-driven self-checking bench for qm_scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qm_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, urs, urt, rw, fl, we, dr;
    logic [4:0]  rs, rt, iwa, wa;
    logic        stall, issue, drained, err;
    logic [31:0] pend;
    logic [15:0] scnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qm_scoreboard dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .ci_IssueValid (valid),
        .di_RS         (rs),
        .di_RT         (rt),
        .ci_UsesRS     (urs),
        .ci_UsesRT     (urt),
        .di_IssueWA    (iwa),
        .ci_RegWrite   (rw),
        .ci_Flush      (fl),
        .di_WA         (wa),
        .di_WE         (we),
        .ci_Drain      (dr),
        .co_Stall      (stall),
        .co_Issue      (issue),
        .co_Drained    (drained),
        .co_Pending    (pend),
        .co_StallCount (scnt),
        .co_Error      (err)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] iwa;
        logic       rw, fl;
        logic [4:0] wa;
        logic       we, dr;
        logic       e_stall, e_issue;
        logic [31:0] e_pend;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic a_urs, input logic a_urt, input logic [4:0] a_iwa,
                       input logic a_rw, input logic a_fl, input logic [4:0] a_wa,
                       input logic a_we, input logic a_dr, input logic es, input logic ei,
                       input logic [31:0] ep, input logic ee);
        vec_t x;
        x.v = v; x.rs = a_rs; x.rt = a_rt; x.urs = a_urs; x.urt = a_urt;
        x.iwa = a_iwa; x.rw = a_rw; x.fl = a_fl; x.wa = a_wa; x.we = a_we; x.dr = a_dr;
        x.e_stall = es; x.e_issue = ei; x.e_pend = ep; x.e_err = ee;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic v, input logic [4:0] a_rs, input logic a_urs,
                         input logic [4:0] a_iwa, input logic a_rw,
                         input logic [4:0] a_wa, input logic a_we, input logic a_dr);
        valid = v; rs = a_rs; rt = 5'd0; urs = a_urs; urt = 1'b0;
        iwa = a_iwa; rw = a_rw; fl = 1'b0; wa = a_wa; we = a_we; dr = a_dr;
    endtask

    // Inputs change at posedge+1, outputs are sampled at negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        //   v rs  rt  urs urt iwa rw fl wa we dr | stall issue pend        err
        add(1, 0,  0,  0,  0,  5, 1, 0, 0, 0, 0,   0, 1, 32'h0,        0); // issue w r5
        add(1, 5,  0,  1,  0,  6, 1, 0, 0, 0, 0,   1, 0, 32'h20,       0); // RAW on r5
        add(1, 5,  0,  1,  0,  6, 1, 0, 5, 1, 0,   1, 0, 32'h20,       0); // retire r5, no bypass
        add(1, 5,  0,  1,  0,  6, 1, 0, 0, 0, 0,   0, 1, 32'h0,        0); // released next cycle
        add(0, 0,  0,  0,  0,  0, 0, 0, 6, 1, 0,   0, 0, 32'h40,       0); // retire r6
        add(1, 0,  0,  0,  0,  7, 1, 0, 0, 0, 0,   0, 1, 32'h0,        0); // r7 #1
        add(1, 0,  0,  0,  0,  7, 1, 0, 0, 0, 0,   0, 1, 32'h80,       0); // r7 #2
        add(1, 0,  0,  0,  0,  7, 1, 0, 0, 0, 0,   0, 1, 32'h80,       0); // r7 #3
        add(1, 0,  0,  0,  0,  7, 1, 0, 0, 0, 0,   1, 0, 32'h80,       0); // WAW overflow
        add(0, 0,  0,  0,  0,  0, 0, 0, 7, 1, 0,   0, 0, 32'h80,       0); // retire 1
        add(0, 0,  0,  0,  0,  0, 0, 0, 7, 1, 0,   0, 0, 32'h80,       0); // retire 2
        add(0, 0,  0,  0,  0,  0, 0, 0, 7, 1, 0,   0, 0, 32'h80,       0); // retire 3
        add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0); // r7 clear
        add(1, 0,  0,  1,  1,  0, 1, 0, 0, 0, 0,   0, 1, 32'h0,        0); // r0 write, RS=RT=0
        add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0); // r0 never pending
        add(1, 0,  0,  0,  0,  9, 1, 0, 0, 0, 0,   0, 1, 32'h0,        0); // issue w r9
        add(1, 0,  0,  0,  0,  9, 1, 0, 9, 1, 0,   0, 1, 32'h200,      0); // issue+retire r9
        add(1, 0,  0,  0,  0,  9, 1, 1, 0, 0, 0,   0, 0, 32'h200,      0); // flushed write r9
        add(1, 0,  0,  0,  0,  9, 1, 1, 9, 1, 0,   0, 0, 32'h200,      0); // flush + retire r9
        add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0); // r9 was exactly 1
        add(0, 0,  0,  0,  0,  0, 0, 0, 3, 1, 0,   0, 0, 32'h0,        0); // bad retire r3
        add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1); // error set
        add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1); // error sticky
        add(1, 0,  0,  0,  0, 12, 1, 0, 0, 0, 0,   0, 1, 32'h0,        1); // issue w r12
        add(1, 12, 12, 0,  0,  0, 0, 0, 0, 0, 0,   0, 1, 32'h1000,     1); // unused operands
        add(1, 0,  12, 0,  1,  0, 0, 0, 0, 0, 0,   1, 0, 32'h1000,     1); // RAW on RT
        add(0, 0,  0,  0,  0,  0, 0, 0, 12, 1, 0,  0, 0, 32'h1000,     1); // retire r12
        add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1); // clear

        // ---- reset behaviour -------------------------------------------
        rst = 1'b1;
        drive(1, 5, 1, 5, 1, 0, 0, 0);
        #2;
        chk("rst_stall",   {31'd0, stall},   32'd0);
        chk("rst_issue",   {31'd0, issue},   32'd1);
        chk("rst_pending", pend,             32'd0);
        chk("rst_drained", {31'd0, drained}, 32'd0);
        chk("rst_scnt",    {16'd0, scnt},    32'd0);
        chk("rst_err",     {31'd0, err},     32'd0);
        @(posedge clk);
        #1 chk("rst_hold_pending", pend, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- table ---------------------------------------------------
        foreach (tbl[i]) begin
            valid = tbl[i].v;  rs = tbl[i].rs; rt = tbl[i].rt;
            urs = tbl[i].urs;  urt = tbl[i].urt; iwa = tbl[i].iwa;
            rw = tbl[i].rw;    fl = tbl[i].fl;  wa = tbl[i].wa;
            we = tbl[i].we;    dr = tbl[i].dr;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i),   {31'd0, stall},   {31'd0, tbl[i].e_stall});
            chk($sformatf("v%0d_issue", i),   {31'd0, issue},   {31'd0, tbl[i].e_issue});
            chk($sformatf("v%0d_pending", i), pend,             tbl[i].e_pend);
            chk($sformatf("v%0d_err", i),     {31'd0, err},     {31'd0, tbl[i].e_err});
            chk($sformatf("v%0d_drained", i), {31'd0, drained}, 32'd0);
            next_cycle();
        end
        chk("table_scnt", {16'd0, scnt}, 32'd4);

        // ---- drain with two writes in flight -------------------------
        do_reset();
        chk("post_rst_err", {31'd0, err}, 32'd0);
        drive(1, 0, 0, 1, 1, 0, 0, 0); next_cycle();          // write r1
        drive(1, 0, 0, 2, 1, 0, 0, 0); next_cycle();          // write r2
        drive(0, 0, 0, 0, 0, 0, 0, 1);                        // drain request
        @(negedge clk);
        chk("drn_req_drained", {31'd0, drained}, 32'd0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 1, 1, 1);                        // in DRAIN, retire r1
        @(negedge clk);
        chk("drn_stall1",  {31'd0, stall},   32'd1);
        chk("drn_issue1",  {31'd0, issue},   32'd0);
        chk("drn_pending", pend,             32'h6);
        chk("drn_drained1",{31'd0, drained}, 32'd0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 2, 1, 0);                        // retire r2
        @(negedge clk);
        chk("drn_stall2",   {31'd0, stall},   32'd1);
        chk("drn_drained2", {31'd0, drained}, 32'd0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);                        // DONE
        @(negedge clk);
        chk("done_drained", {31'd0, drained}, 32'd1);
        chk("done_stall",   {31'd0, stall},   32'd1);
        chk("done_issue",   {31'd0, issue},   32'd0);
        chk("done_pending", pend,             32'd0);
        next_cycle();
        drive(1, 0, 0, 4, 1, 0, 0, 0);                        // back in RUN, write r4
        @(negedge clk);
        chk("run_drained", {31'd0, drained}, 32'd0);
        chk("run_issue",   {31'd0, issue},   32'd1);
        next_cycle();
        drive(1, 4, 1, 0, 0, 0, 0, 0);                        // RAW on r4 for 37 cycles
        repeat (37) next_cycle();
        chk("scnt_40", {16'd0, scnt}, 32'd40);
        drive(0, 0, 0, 0, 0, 4, 1, 0); next_cycle();          // retire r4
        chk("scnt_hold", {16'd0, scnt}, 32'd40);

        // ---- reset mid-drain -----------------------------------------
        drive(1, 0, 0, 8, 1, 0, 0, 0); next_cycle();          // write r8
        drive(0, 0, 0, 0, 0, 0, 0, 1); next_cycle();          // enter DRAIN
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pending", pend,            32'd0);
        chk("mid_rst_scnt",    {16'd0, scnt},   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (drained) seen++;
                next_cycle();
            end
            chk("mid_rst_no_drained", seen, 32'd0);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst_run_issue", {31'd0, issue}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/qm_scoreboard.md
QM_SCOREBOARD -- requirements
Module: qm_scoreboard

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning), clock and reset first:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  asynchronous active-high reset.
- ci_IssueValid  in  1  decode holds a valid instruction.
- di_RS  in  5  source register A of the decode instruction.
- di_RT  in  5  source register B of the decode instruction.
- ci_UsesRS  in  1  instruction reads RS.
- ci_UsesRT  in  1  instruction reads RT.
- di_IssueWA  in  5  destination register of the decode instruction.
- ci_RegWrite  in  1  instruction writes di_IssueWA.
- ci_Flush  in  1  kill the decode instruction this cycle.
- di_WA  in  5  writeback address (same signal that feeds the regfile).
- di_WE  in  1  writeback enable.
- ci_Drain  in  1  request a pipeline drain (one-cycle pulse).
- co_Stall  out  1  hold fetch/decode and insert a bubble.
- co_Issue  out  1  decode instruction accepted this cycle.
- co_Drained  out  1  one-cycle pulse when the drain completes.
- co_Pending  out  32  bit n = 1 while register n has an in-flight write.
- co_StallCount  out  16  saturating count of stalled cycles.
- co_Error  out  1  sticky flag: retire seen with no pending write.

Function
REQ-003 The block SHALL keep a 2-bit in-flight write counter cnt[n] for each register n = 1..31.
REQ-004 Register 0 SHALL never be pending: cnt[0] is constant 0 and co_Pending[0] is constant 0.
REQ-005 co_Pending[n] SHALL equal (cnt[n] != 0), driven combinationally from state.
REQ-006 A RAW hazard SHALL be: (ci_UsesRS & di_RS != 0 & cnt[di_RS] != 0) | (ci_UsesRT & di_RT != 0 & cnt[di_RT] != 0).
REQ-007 A WAW overflow SHALL be: ci_RegWrite & di_IssueWA != 0 & cnt[di_IssueWA] == 3.
REQ-008 co_Stall SHALL be combinational and equal: ci_IssueValid & !ci_Flush & (RAW | WAW overflow | state != RUN).
REQ-009 There SHALL be no same-cycle bypass: a retire in cycle t does not clear a stall in cycle t; the stall releases in cycle t+1.
REQ-010 co_Issue SHALL equal ci_IssueValid & !ci_Flush & !co_Stall.
REQ-011 On co_Issue with ci_RegWrite and di_IssueWA != 0, cnt[di_IssueWA] SHALL increment at the next edge.
REQ-012 On di_WE with di_WA != 0 and cnt[di_WA] > 0, cnt[di_WA] SHALL decrement at the next edge.
REQ-013 On di_WE with di_WA != 0 and cnt[di_WA] == 0, the counter SHALL remain 0 and co_Error SHALL set and stay set until reset.
REQ-014 An issue and a retire to the same register in the same cycle SHALL leave cnt unchanged.
REQ-015 A flushed instruction SHALL NOT modify any cnt; retires in the same cycle SHALL still apply.
REQ-016 The FSM SHALL have three states: RUN, DRAIN, DONE.
- RUN -> DRAIN on ci_Drain.
- DRAIN -> DONE when all cnt == 0 (evaluated on the post-update state).
- DONE -> RUN unconditionally after one cycle.
REQ-017 ci_Drain SHALL be ignored outside RUN.
REQ-018 co_Drained SHALL be 1 exactly while in DONE (one cycle).
REQ-019 While in DRAIN or DONE, co_Issue SHALL be 0; retires SHALL continue to decrement counters.
REQ-020 co_StallCount SHALL increment on each edge where co_Stall = 1 and saturate at 0xFFFF.
REQ-021 Latency: a dependent instruction issues no earlier than the cycle after the retire of its producer.

Reset
REQ-022 Asserting sys_rst SHALL immediately (asynchronously) set all cnt to 0, the FSM to RUN, co_StallCount to 0 and co_Error to 0.
REQ-023 During reset, co_Pending SHALL be 0, co_Drained SHALL be 0, and co_Stall and co_Issue SHALL follow REQ-008 and REQ-010 with empty state.
REQ-024 Reset asserted mid-drain SHALL abandon the drain without producing a co_Drained pulse.

Verification
REQ-025 The bench SHALL cover at least these scenarios:
- Issue write r5, then next instruction uses RS = 5 -> co_Stall = 1 until the cycle after di_WE/di_WA = 5; co_Pending[5] drops at that edge.
- Three issues writing r7 with no retire, then a fourth -> co_Stall = 1 (WAW overflow); co_Pending[7] = 1 until the third retire.
- Issue writing r0 with RS = 0 -> no stall, co_Pending = 0.
- Issue r9 and retire r9 in the same cycle with cnt[9] = 1 -> cnt[9] stays 1; ci_Flush on an r9 write -> no change.
- Retire r3 with cnt[3] = 0 -> co_Error = 1 and stays set; cnt[3] stays 0.
- ci_Drain with two writes in flight -> DRAIN; stall until both retire; co_Drained is high one cycle; then RUN; 40 stall cycles give co_StallCount = 40.
